mul_div_int: RTL

//  Iterative RV32M multiply/divide unit for the EX stage. It takes the same OP1/OP2 operand bus as
//  the integer ALU, and its RESULT goes to the EX result mux next to the ALU RESULT. While it

---
 rtl/mul_div_if.sv | 16 +
 rtl/mul_div_int.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mul_div_if.sv
// Operand/result bundle shared between the EX stage and the mul/div unit.
interface mul_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             flush;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (output start, funct3, op1, op2, flush,
                  input  result, busy, done);
  modport slave  (input  start, funct3, op1, op2, flush,
                  output result, busy, done);
endinterface

// File: rtl/mul_div_int.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// sign fixup in the final cycle, early exit for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for start; result held
// CALC  | 32 shift-add / restoring-divide iterations
// FIN   | sign fixup, load result, pulse done
module mul_div_int #(
  parameter int WIDTH     = 32,
  parameter bit FAST_SPEC = 1'b1
) (
  input logic      clk,
  input logic      rst,
  mul_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t             state, state_next;
  logic [5:0]         cnt;
  logic [2:0]         f3;
  logic [WIDTH-1:0]   opd;          // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0] acc;          // {hi, multiplier} or {remainder, dividend/quotient}
  logic               neg;
  logic               special;
  logic [WIDTH-1:0]   special_val;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;
  logic               done_q;

  logic               accept;
  logic               is_div, s1, s2, neg_in, div0, ovf, special_in;
  logic [WIDTH-1:0]   mag1, mag2, special_val_in;
  logic [WIDTH:0]     sum, trial, diff;
  logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix, fin_val;

  assign accept = (state == IDLE) && bus.start && !bus.flush;

  // Decode signedness and special cases of the operands presented with start
  always_comb begin
    is_div = bus.funct3[2];
    s1     = bus.op1[WIDTH-1] & (is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11));
    s2     = bus.op2[WIDTH-1] & (is_div ? ~bus.funct3[0] : ~bus.funct3[1]);
    mag1   = s1 ? (~bus.op1 + 1'b1) : bus.op1;
    mag2   = s2 ? (~bus.op2 + 1'b1) : bus.op2;
    // remainder follows the dividend's sign, everything else the sign product
    neg_in = (is_div && bus.funct3[1]) ? s1 : (s1 ^ s2);
    div0   = is_div && (bus.op2 == '0);
    ovf    = is_div && !bus.funct3[0] &&
             (bus.op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.op2 == '1);
    special_in = div0 || ovf;
    if (div0)
      special_val_in = bus.funct3[1] ? bus.op1 : '1;
    else
      special_val_in = bus.funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

  // One iteration of shift-add multiply and restoring divide, plus final sign fixup
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    mul_step = {sum, acc[WIDTH-1:1]};
    trial    = acc[2*WIDTH-1:WIDTH-1];
    diff     = trial - {1'b0, opd};
    if (!diff[WIDTH])
      div_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    prod_fix = neg ? (~acc + 1'b1) : acc;
    q_fix    = neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    r_fix    = neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    if (special)
      fin_val = special_val;
    else if (!f3[2])
      fin_val = (f3[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    else
      fin_val = f3[1] ? r_fix : q_fix;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush aborts from any busy state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (FAST_SPEC && special_in) ? FIN : CALC;
      CALC: if (bus.flush) state_next = IDLE;
            else if (cnt == 6'(WIDTH-1)) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      f3          <= '0;
      opd         <= '0;
      acc         <= '0;
      neg         <= 1'b0;
      special     <= 1'b0;
      special_val <= '0;
    end else if (accept) begin
      cnt         <= '0;
      f3          <= bus.funct3;
      opd         <= is_div ? mag2 : mag1;
      acc         <= {{WIDTH{1'b0}}, (is_div ? mag1 : mag2)};
      neg         <= neg_in;
      special     <= special_in;
      special_val <= special_val_in;
    end else if (state == CALC && !bus.flush) begin
      acc <= f3[2] ? div_step : mul_step;
      cnt <= (cnt == 6'(WIDTH-1)) ? '0 : cnt + 1'b1;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= (state_next != IDLE);
      done_q <= (state == FIN) && !bus.flush;
      if (state == FIN && !bus.flush) result_q <= fin_val;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
